// File: rtl/game_pkg.sv
// Shared constants for the memory-game controller:
// FSM state codes and datapath input widths.
package game_pkg;

   localparam logic [2:0] INIT       = 3'd0;
   localparam logic [2:0] SETUP      = 3'd1;
   localparam logic [2:0] SEQUENCE   = 3'd2;
   localparam logic [2:0] PLAY       = 3'd3;
   localparam logic [2:0] CHECK      = 3'd4;
   localparam logic [2:0] NEXT_ROUND = 3'd5;
   localparam logic [2:0] RESULT     = 3'd6;

   localparam int P_KEY    = 4;
   localparam int P_SWITCH = 8;

endpackage

// File: rtl/key_edge.sv
// Push-button synchroniser and falling-edge detector;
// emits one pulse per press of an active-low key.
module key_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic key_n,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   primed;
   logic                   armed;

   // armed only after a real released sample is seen, so a key
   // held through reset cannot fake an edge off the reset value
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync   <= '1;
         prev   <= 1'b1;
         primed <= 1'b0;
         armed  <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], key_n};
         prev   <= sync[SYNC_STAGES-1];
         primed <= 1'b1;
         armed  <= armed | (primed & sync[0]);
      end
   end

   assign pulse = armed & prev & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/game_controller.sv
// Control FSM of the memory game: Moore outputs drive
// datapath resets/enables, status inputs steer the rounds.
module game_controller
   import game_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       ENTER,
   input  logic       end_FPGA,
   input  logic       end_User,
   input  logic       end_time,
   input  logic       win,
   input  logic       match,
   output logic       R1,
   output logic       R2,
   output logic       E1,
   output logic       E2,
   output logic       E3,
   output logic       E4,
   output logic       SEL,
   output logic [2:0] state
);

   logic       enter_pulse;
   logic [2:0] next;

   key_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_key (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .key_n   (ENTER),
      .pulse   (enter_pulse)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state <= INIT;
      else          state <= next;
   end

   // end_time is tested first in PLAY so a simultaneous press is dropped
   always_comb begin
      next = state;
      case (state)
         INIT:     next = SETUP;
         SETUP:    if (enter_pulse) next = SEQUENCE;
         SEQUENCE: if (end_FPGA) next = PLAY;
         PLAY: begin
            if (end_time)         next = RESULT;
            else if (enter_pulse) next = CHECK;
         end
         CHECK: begin
            if (!match)        next = RESULT;
            else if (end_User) next = NEXT_ROUND;
            else               next = PLAY;
         end
         NEXT_ROUND: next = win ? RESULT : SEQUENCE;
         RESULT:     if (enter_pulse) next = INIT;
         default:    next = INIT;
      endcase
   end

   always_comb begin
      R1  = 1'b0;
      R2  = 1'b0;
      E1  = 1'b0;
      E2  = 1'b0;
      E3  = 1'b0;
      E4  = 1'b0;
      SEL = 1'b0;
      case (state)
         INIT: begin
            R1 = 1'b1;
            R2 = 1'b1;
         end
         SETUP: E1 = 1'b1;
         SEQUENCE: begin
            E3 = 1'b1;
            R2 = 1'b1;
         end
         PLAY:       E2  = 1'b1;
         CHECK:      E4  = 1'b1;
         NEXT_ROUND: R2  = 1'b1;
         RESULT:     SEL = 1'b1;
         default: ;
      endcase
   end

endmodule
